// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC bus trace decoder: FSM states, bus codes,
// record status encoding and the record layout pushed into the trace FIFO.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TAR1,
        ST_SYNC,
        ST_RDATA,
        ST_TAR2,
        ST_SKIP
    } lpc_state_e;

    typedef enum logic [2:0] {
        STATUS_OK          = 3'd0,
        STATUS_SYNC_ERR    = 3'd1,
        STATUS_ABORT       = 3'd2,
        STATUS_TIMEOUT     = 3'd3,
        STATUS_UNSUPPORTED = 3'd4
    } lpc_status_e;

    localparam logic [3:0] START_CODE      = 4'b0000;
    localparam logic [1:0] CYC_IO          = 2'b00;
    localparam logic [1:0] CYC_MEM         = 2'b01;
    localparam int unsigned DIR_WRITE_BIT  = 1;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_READY_ALT  = 4'b1001;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    localparam int unsigned IO_ADDR_NIBBLES  = 4;
    localparam int unsigned MEM_ADDR_NIBBLES = 8;

    localparam int unsigned CYC_W    = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned STATUS_W = 3;
    localparam int unsigned WAIT_W   = 8;

    typedef struct packed {
        logic [CYC_W-1:0]    cyctype_dir;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [STATUS_W-1:0] status;
    } lpc_record_t;

    localparam int unsigned REC_W          = $bits(lpc_record_t);
    localparam int unsigned REC_STATUS_LSB = 0;
    localparam int unsigned REC_DATA_LSB   = REC_STATUS_LSB + STATUS_W;
    localparam int unsigned REC_ADDR_LSB   = REC_DATA_LSB + DATA_W;
    localparam int unsigned REC_CYC_LSB    = REC_ADDR_LSB + ADDR_W;

endpackage

// File: rtl/lpc_record_fifo.sv
// First-word-fall-through record buffer with a registered head stage; a record
// pushed into an empty buffer becomes visible one clock after the push.
module lpc_record_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 47
) (
    input  logic                   lpc_clock,
    input  logic                   lpc_reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_record,
    input  logic                   ready,
    output logic                   valid,
    output logic [WIDTH-1:0]       head,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] mem_count;
    logic             pop_c;
    logic             accept_c;
    logic             load_c;

    // level counts the head register too, so a full buffer still accepts when the head leaves
    assign pop_c    = valid & ready;
    assign accept_c = push & ((level != LVL_W'(DEPTH)) | pop_c);
    assign load_c   = (mem_count != '0) & (~valid | pop_c);

    always_ff @(posedge lpc_clock) begin
        if (accept_c) begin
            mem[wr_ptr] <= push_record;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            level     <= '0;
            valid     <= 1'b0;
            head      <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            mem_count <= mem_count + LVL_W'(accept_c) - LVL_W'(load_c);
            level     <= level + LVL_W'(accept_c) - LVL_W'(pop_c);
            if (load_c) begin
                valid <= 1'b1;
                head  <= mem[rd_ptr];
            end else if (pop_c) begin
                valid <= 1'b0;
            end
            if (push & ~accept_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lpc_trace_decoder.sv
// Passive LPC bus monitor: decodes I/O and memory cycles from lpc_ad/lpc_frame
// and queues one trace record per started cycle.
module lpc_trace_decoder
    import lpc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned SYNC_TIMEOUT = 16
) (
    input  logic                        lpc_clock,
    input  logic                        lpc_reset,
    input  logic [3:0]                  lpc_ad,
    input  logic                        lpc_frame,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [3:0]                  out_cyctype_dir,
    output logic [31:0]                 out_addr,
    output logic [7:0]                  out_data,
    output logic [2:0]                  out_status,
    output logic                        out_overflow,
    output logic [$clog2(FIFO_DEPTH):0] out_level
);

    lpc_state_e          state;
    logic [2:0]          cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CYC_W-1:0]    cur_cyc;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;
    logic [STATUS_W-1:0] cur_status;
    logic                push_c;
    lpc_record_t         rec_c;
    lpc_record_t         head_rec;
    logic                is_write;
    logic                is_ready_sync;
    logic                is_wait_sync;
    logic                timeout_hit;

    assign is_write      = cur_cyc[DIR_WRITE_BIT];
    assign is_ready_sync = (lpc_ad == SYNC_READY) | (lpc_ad == SYNC_READY_ALT);
    assign is_wait_sync  = (lpc_ad == SYNC_SHORT_WAIT) | (lpc_ad == SYNC_LONG_WAIT);
    assign timeout_hit   = (wait_cnt == WAIT_W'(SYNC_TIMEOUT));

    // Record push decode: fires on the edge that samples a cycle's terminating nibble.
    // START repetition in CYCTYPE and a frame drop in TAR2 push nothing: the cycle
    // has either not begun or already been recorded.
    always_comb begin
        push_c            = 1'b0;
        rec_c.cyctype_dir = cur_cyc;
        rec_c.addr        = cur_addr;
        rec_c.data        = cur_data;
        rec_c.status      = cur_status;
        if (!lpc_frame) begin
            if (state inside {ST_ADDR, ST_WDATA, ST_TAR1, ST_SYNC, ST_RDATA}) begin
                push_c       = 1'b1;
                rec_c.status = STATUS_ABORT;
            end
        end else begin
            case (state)
                ST_CYCTYPE: begin
                    if (!(lpc_ad[3:2] inside {CYC_IO, CYC_MEM})) begin
                        push_c            = 1'b1;
                        rec_c.cyctype_dir = lpc_ad;
                        rec_c.status      = STATUS_UNSUPPORTED;
                    end
                end
                ST_SYNC: begin
                    if (is_ready_sync) begin
                        push_c       = is_write;
                        rec_c.status = STATUS_OK;
                    end else if (lpc_ad == SYNC_ERROR) begin
                        push_c       = is_write;
                        rec_c.status = STATUS_SYNC_ERR;
                    end else if (is_wait_sync) begin
                        push_c       = timeout_hit;
                        rec_c.status = STATUS_TIMEOUT;
                    end else begin
                        push_c       = 1'b1;
                        rec_c.status = STATUS_SYNC_ERR;
                    end
                end
                ST_RDATA: begin
                    if (cnt[0]) begin
                        push_c     = 1'b1;
                        rec_c.data = {lpc_ad, cur_data[3:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wait_cnt   <= '0;
            cur_cyc    <= '0;
            cur_addr   <= '0;
            cur_data   <= '0;
            cur_status <= STATUS_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!lpc_frame && lpc_ad == START_CODE) begin
                        state      <= ST_CYCTYPE;
                        cnt        <= '0;
                        wait_cnt   <= '0;
                        cur_cyc    <= '0;
                        cur_addr   <= '0;
                        cur_data   <= '0;
                        cur_status <= STATUS_OK;
                    end
                end
                ST_SKIP: begin
                    if (lpc_frame) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (!lpc_frame) begin
                        if (lpc_ad == START_CODE) begin
                            state      <= ST_CYCTYPE;
                            cnt        <= '0;
                            wait_cnt   <= '0;
                            cur_cyc    <= '0;
                            cur_addr   <= '0;
                            cur_data   <= '0;
                            cur_status <= STATUS_OK;
                        end else begin
                            state <= (state == ST_CYCTYPE) ? ST_IDLE : ST_SKIP;
                        end
                    end else begin
                        case (state)
                            ST_CYCTYPE: begin
                                cur_cyc <= lpc_ad;
                                cnt     <= (lpc_ad[3:2] == CYC_MEM) ? 3'(MEM_ADDR_NIBBLES - 1)
                                                                    : 3'(IO_ADDR_NIBBLES - 1);
                                state   <= (lpc_ad[3:2] inside {CYC_IO, CYC_MEM}) ? ST_ADDR : ST_SKIP;
                            end
                            ST_ADDR: begin
                                // nibbles land in their final position so a partial address keeps its weight
                                cur_addr[{cnt, 2'b00} +: 4] <= lpc_ad;
                                if (cnt == 3'd0) begin
                                    state <= is_write ? ST_WDATA : ST_TAR1;
                                end else begin
                                    cnt <= cnt - 3'd1;
                                end
                            end
                            ST_WDATA: begin
                                if (cnt == 3'd0) begin
                                    cur_data[3:0] <= lpc_ad;
                                    cnt           <= 3'd1;
                                end else begin
                                    cur_data[7:4] <= lpc_ad;
                                    cnt           <= 3'd0;
                                    state         <= ST_TAR1;
                                end
                            end
                            ST_TAR1: begin
                                if (cnt == 3'd0) begin
                                    cnt <= 3'd1;
                                end else begin
                                    cnt      <= 3'd0;
                                    wait_cnt <= '0;
                                    state    <= ST_SYNC;
                                end
                            end
                            ST_SYNC: begin
                                if (is_ready_sync || lpc_ad == SYNC_ERROR) begin
                                    cnt   <= 3'd0;
                                    state <= is_write ? ST_TAR2 : ST_RDATA;
                                    if (lpc_ad == SYNC_ERROR) begin
                                        cur_status <= STATUS_SYNC_ERR;
                                    end
                                end else if (is_wait_sync) begin
                                    if (timeout_hit) begin
                                        state <= ST_SKIP;
                                    end else begin
                                        wait_cnt <= wait_cnt + WAIT_W'(1);
                                    end
                                end else begin
                                    state <= ST_SKIP;
                                end
                            end
                            ST_RDATA: begin
                                if (cnt == 3'd0) begin
                                    cur_data[3:0] <= lpc_ad;
                                    cnt           <= 3'd1;
                                end else begin
                                    cur_data[7:4] <= lpc_ad;
                                    cnt           <= 3'd0;
                                    state         <= ST_TAR2;
                                end
                            end
                            ST_TAR2: begin
                                if (cnt == 3'd0) begin
                                    cnt <= 3'd1;
                                end else begin
                                    cnt   <= 3'd0;
                                    state <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    lpc_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .lpc_clock   (lpc_clock),
        .lpc_reset   (lpc_reset),
        .push        (push_c),
        .push_record (rec_c),
        .ready       (out_ready),
        .valid       (out_valid),
        .head        (head_rec),
        .overflow    (out_overflow),
        .level       (out_level)
    );

    assign out_cyctype_dir = head_rec.cyctype_dir;
    assign out_addr        = head_rec.addr;
    assign out_data        = head_rec.data;
    assign out_status      = head_rec.status;

endmodule

// File: tb/tb_lpc_trace_decoder.sv
// Directed bench for lpc_trace_decoder, built with a 2-deep FIFO and a 4-nibble sync timeout.
module tb_lpc_trace_decoder;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b0;
    logic [3:0]  lpc_ad    = 4'hF;
    logic        lpc_frame = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [7:0]  out_data;
    logic [2:0]  out_status;
    logic        out_overflow;
    logic [1:0]  out_level;

    int vectors    = 0;
    int miscompares = 0;

    lpc_trace_decoder #(
        .FIFO_DEPTH   (2),
        .SYNC_TIMEOUT (4)
    ) dut (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .lpc_ad          (lpc_ad),
        .lpc_frame       (lpc_frame),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_cyctype_dir (out_cyctype_dir),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .out_status      (out_status),
        .out_overflow    (out_overflow),
        .out_level       (out_level)
    );

    always #5 lpc_clock = ~lpc_clock;

    // {valid, cyctype, addr, data, status, overflow}
    function automatic logic [48:0] head_now();
        return {out_valid, out_cyctype_dir, out_addr, out_data, out_status, out_overflow};
    endfunction

    task automatic drive(input logic f, input logic [3:0] a);
        lpc_frame = f;
        lpc_ad    = a;
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic send_header(input logic [3:0] cyc, input logic [31:0] addr, input int n);
        drive(1'b0, 4'h0);
        drive(1'b1, cyc);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, addr[4*i +: 4]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(1'b1, b[3:0]);
        drive(1'b1, b[7:4]);
    endtask

    task automatic tar();
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] d);
        send_header(4'h2, {16'h0, addr}, 4);
        send_byte(d);
        tar();
        drive(1'b1, 4'h0);
        tar();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        drive(1'b1, 4'hF);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({head_now(), out_level} !== 51'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", {head_now(), out_level});
        end
        #2 lpc_reset = 1'b1;
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
    endtask

    task automatic test_io_write();
        send_header(4'h2, 32'h80, 4);
        send_byte(8'h5A);
        tar();
        drive(1'b1, 4'h0);
        vectors++;
        if ({out_valid, out_level} !== {1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL io_write_latency: got valid=%b level=%0d want valid=0 level=1", out_valid, out_level);
        end
        drive(1'b1, 4'hF);
        vectors++;
        if (head_now() !== {1'b1, 4'h2, 32'h80, 8'h5A, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL io_write_record: got %h want %h", head_now(), {1'b1, 4'h2, 32'h80, 8'h5A, 3'd0, 1'b0});
        end
        drive(1'b1, 4'hF);
        pop_one();
        vectors++;
        if ({head_now(), out_level} !== {1'b0, 4'h2, 32'h80, 8'h5A, 3'd0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL io_write_empty_hold: got %h", {head_now(), out_level});
        end
    endtask

    task automatic test_mem_read();
        send_header(4'h4, 32'hFFFF_FFF0, 8);
        tar();
        drive(1'b1, 4'h6);
        drive(1'b1, 4'h6);
        drive(1'b1, 4'h0);
        send_byte(8'h5A);
        tar();
        vectors++;
        if ({head_now(), out_level} !== {1'b1, 4'h4, 32'hFFFF_FFF0, 8'h5A, 3'd0, 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL mem_read_record: got %h", {head_now(), out_level});
        end
        pop_one();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_read_pop: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_timeout();
        send_header(4'h0, 32'h60, 4);
        tar();
        for (int i = 0; i < 5; i++) drive(1'b1, 4'h5);
        drive(1'b1, 4'hF);
        vectors++;
        if (head_now() !== {1'b1, 4'h0, 32'h60, 8'h00, 3'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_record: got %h want %h", head_now(), {1'b1, 4'h0, 32'h60, 8'h00, 3'd3, 1'b0});
        end
        pop_one();
        // exactly SYNC_TIMEOUT waits is still a good cycle
        send_header(4'h0, 32'h61, 4);
        tar();
        for (int i = 0; i < 4; i++) drive(1'b1, 4'h6);
        drive(1'b1, 4'h9);
        send_byte(8'hC3);
        tar();
        vectors++;
        if (head_now() !== {1'b1, 4'h0, 32'h61, 8'hC3, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_boundary: got %h want %h", head_now(), {1'b1, 4'h0, 32'h61, 8'hC3, 3'd0, 1'b0});
        end
        pop_one();
    endtask

    task automatic test_sync_error();
        send_header(4'h0, 32'h100, 4);
        tar();
        drive(1'b1, 4'hA);
        send_byte(8'hE7);
        tar();
        vectors++;
        if (head_now() !== {1'b1, 4'h0, 32'h100, 8'hE7, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL sync_err_read: got %h", head_now());
        end
        pop_one();
        send_header(4'h2, 32'h200, 4);
        send_byte(8'h33);
        tar();
        drive(1'b1, 4'h3);
        drive(1'b1, 4'hF);
        vectors++;
        if ({head_now(), out_level} !== {1'b1, 4'h2, 32'h200, 8'h33, 3'd1, 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL sync_bad_write: got %h", {head_now(), out_level});
        end
        pop_one();
    endtask

    task automatic test_abort();
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h1);
        drive(1'b1, 4'h2);
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h2);
        for (int i = 0; i < 4; i++) drive(1'b1, (i < 2) ? 4'h0 : 4'h4);
        send_byte(8'h21);
        tar();
        drive(1'b1, 4'h0);
        tar();
        vectors++;
        if ({head_now(), out_level} !== {1'b1, 4'h0, 32'h1200, 8'h00, 3'd2, 1'b0, 2'd2}) begin
            miscompares++;
            $display("FAIL abort_record: got %h", {head_now(), out_level});
        end
        pop_one();
        vectors++;
        if (head_now() !== {1'b1, 4'h2, 32'h44, 8'h21, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_restart: got %h", head_now());
        end
        pop_one();
    endtask

    task automatic test_overflow();
        io_write(16'h0010, 8'h01);
        io_write(16'h0020, 8'h02);
        io_write(16'h0030, 8'h03);
        vectors++;
        if ({head_now(), out_level} !== {1'b1, 4'h2, 32'h10, 8'h01, 3'd0, 1'b1, 2'd2}) begin
            miscompares++;
            $display("FAIL overflow_full: got %h", {head_now(), out_level});
        end
        pop_one();
        vectors++;
        if ({head_now(), out_level} !== {1'b1, 4'h2, 32'h20, 8'h02, 3'd0, 1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL overflow_drain1: got %h", {head_now(), out_level});
        end
        pop_one();
        vectors++;
        if ({head_now(), out_level} !== {1'b0, 4'h2, 32'h20, 8'h02, 3'd0, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL overflow_drain2: got %h", {head_now(), out_level});
        end
    endtask

    task automatic test_unsupported_reset();
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h8);
        drive(1'b1, 4'hF);
        vectors++;
        if (head_now() !== {1'b1, 4'h8, 32'h0, 8'h00, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL unsupported_record: got %h", head_now());
        end
        pop_one();
        send_header(4'h0, 32'h1200, 2);
        lpc_reset = 1'b0;
        #2;
        vectors++;
        if ({head_now(), out_level} !== 51'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0", {head_now(), out_level});
        end
        #2 lpc_reset = 1'b1;
        @(posedge lpc_clock);
        #1;
        drive(1'b1, 4'h3);
        drive(1'b1, 4'h4);
        tar();
        for (int i = 0; i < 4; i++) drive(1'b1, 4'h0);
        vectors++;
        if ({head_now(), out_level} !== 51'h0) begin
            miscompares++;
            $display("FAIL reset_discard: got %h want 0", {head_now(), out_level});
        end
        io_write(16'h0ABC, 8'h99);
        vectors++;
        if (head_now() !== {1'b1, 4'h2, 32'hABC, 8'h99, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_recover: got %h", head_now());
        end
    endtask

    initial begin
        test_reset();
        test_io_write();
        test_mem_read();
        test_timeout();
        test_sync_error();
        test_abort();
        test_overflow();
        test_unsupported_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lpc_trace_decoder.md
LPC_TRACE_DECODER -- requirements
Module: lpc_trace_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of buffered cycle records; power of two, minimum 2.
REQ-002 Parameter SYNC_TIMEOUT, default 16, maximum consecutive wait-sync nibbles (0101/0110) before a cycle is abandoned; range 1..255.
REQ-003 lpc_clock  input  1  LPC clock; all sampling on the rising edge.
REQ-004 lpc_reset  input  1  asynchronous, active-low reset.
REQ-005 lpc_ad  input  4  LPC address/data nibble bus.
REQ-006 lpc_frame  input  1  LPC frame, active low.
REQ-007 out_ready  input  1  consumer accepts the head record when high with out_valid.
REQ-008 out_valid  output  1  head record present.
REQ-009 out_cyctype_dir  output  4  cycle type/direction nibble as sampled in the cycle.
REQ-010 out_addr  output  32  address; I/O cycles zero-extended from 16 bits.
REQ-011 out_data  output  8  data byte; 0 when no data phase completed.
REQ-012 out_status  output  3  0 OK, 1 SYNC_ERR, 2 ABORT, 3 TIMEOUT, 4 UNSUPPORTED.
REQ-013 out_overflow  output  1  sticky: a record was dropped due to a full FIFO.
REQ-014 out_level  output  $clog2(FIFO_DEPTH)+1  records currently buffered.

Function
REQ-015 FSM states: IDLE, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2, SKIP.
REQ-016 IDLE -> CYCTYPE when lpc_frame=0 and lpc_ad=0000; other start codes are ignored; while lpc_frame stays low, the last sampled START nibble is the one used.
REQ-017 CYCTYPE: lpc_ad[3:2]=00 (I/O) -> ADDR, 4 nibbles; 01 (memory) -> ADDR, 8 nibbles; 10/11 (DMA/reserved) -> push UNSUPPORTED record, -> SKIP.
REQ-018 ADDR captures address MSB nibble first; after the last nibble: write (cyctype bit 1 = 1) -> WDATA; read -> TAR1.
REQ-019 WDATA captures 2 nibbles, low nibble first, then -> TAR1; TAR1 lasts exactly 2 cycles -> SYNC.
REQ-020 SYNC: 0000 or 1001 -> read: RDATA; write: push OK record, -> TAR2. 0101/0110 -> stay, increment wait counter. 1010 -> read: RDATA with status SYNC_ERR; write: push SYNC_ERR record, -> TAR2. Any other nibble -> push SYNC_ERR, -> SKIP.
REQ-021 Wait counter resets on entering SYNC; on the cycle the (SYNC_TIMEOUT+1)-th consecutive wait nibble is sampled: push TIMEOUT record, -> SKIP.
REQ-022 RDATA captures 2 nibbles, low nibble first; push record on the edge the second nibble is sampled, -> TAR2; TAR2 lasts 2 cycles -> IDLE.
REQ-023 SKIP -> IDLE on the first edge with lpc_frame=1.
REQ-024 In any state other than IDLE/SKIP, lpc_frame=0 terminates the cycle: push ABORT record with fields captured so far (uncaptured fields 0); then lpc_ad=0000 -> CYCTYPE, else -> SKIP.
REQ-025 Abort/start on lpc_frame takes priority over every other transition in the same cycle.
REQ-026 Exactly one record is pushed per cycle started; push occurs on the rising edge where the terminating nibble is sampled.
REQ-027 FIFO is first-word-fall-through; out_valid asserts on the rising edge after a push into an empty FIFO (1-cycle latency).
REQ-028 Pop when out_valid & out_ready; outputs hold stable while out_valid & ~out_ready.
REQ-029 Push when full and no pop: record dropped, out_overflow set; push and pop in the same cycle when full: both succeed, level unchanged.
REQ-030 Pointers wrap modulo FIFO_DEPTH; out_level never exceeds FIFO_DEPTH.
REQ-031 When empty: out_valid=0, other record outputs hold the last popped value.

Reset
REQ-032 lpc_reset low asynchronously forces state IDLE, counters 0, FIFO empty, out_valid 0, out_overflow 0, record outputs 0, out_level 0.
REQ-033 Reset mid-cycle discards the partial cycle; no record is pushed for it.
REQ-034 out_overflow clears only on reset.

Structure
REQ-035 Shared package lpc_pkg holds the FSM state enum, cycle-type constants, sync codes, status encoding, and record width/field offsets.
REQ-036 Record buffering is sub-module lpc_record_fifo (parameter DEPTH, WIDTH), instantiated once.

Verification
REQ-037 I/O write 0x0080 data 0x5A, sync 0000 -> one record: cyctype 0010, addr 0x00000080, data 0x5A, status 0, out_valid one cycle after the sync nibble.
REQ-038 Memory read 0xFFFFFFF0, two 0110 waits then 0000, data nibbles A,5 -> record: cyctype 0100, data 0x5A, status 0.
REQ-039 I/O read with SYNC_TIMEOUT=4 and 5 waits -> TIMEOUT record with data 0; FSM returns to IDLE once lpc_frame is 1.
REQ-040 lpc_frame=0 with AD=0000 during ADDR nibble 3 -> ABORT record with partial addr, followed by correct decode of the new cycle.
REQ-041 FIFO_DEPTH=2, out_ready=0, three cycles -> two records kept, out_overflow=1, out_level=2; out_ready=1 drains in order.
REQ-042 DMA cyctype 1000 -> UNSUPPORTED record; lpc_reset pulse mid-ADDR -> no record pushed, all outputs 0.
